// File: rtl/counter_share_pkg.sv
// Shared types and helpers for the counter-sharing scheduler.
// The optional COUNTER_PRESCALE_EN feature lives in the top level; this package is build-independent.
package counter_share_pkg;

    localparam int WIDTH_DEFAULT = 27;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } pick_t;

    // Search upward from pointer+1 (mod nreq); sized for the 16-requester maximum.
    function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] pointer,
                                      input int nreq);
        pick_t res;
        int    cand;
        res = '0;
        for (int step_i = 1; step_i <= 16; step_i++) begin
            cand = (int'(pointer) + step_i) % nreq;
            if (step_i <= nreq && !res.valid && req[cand[3:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_share_scheduler_arbiter.sv
// Combinational round-robin picker; the pointer register is owned by the scheduler.
// Independent of COUNTER_PRESCALE_EN.
module rr_arbiter_onehot
    import counter_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  pointer,
    output logic [NREQ-1:0]          onehot,
    output logic [$clog2(NREQ)-1:0]  sel,
    output logic                     valid
);

    logic [15:0] req_wide;
    logic [3:0]  ptr_wide;
    pick_t       pick;

    always_comb begin
        req_wide                      = '0;
        req_wide[NREQ-1:0]            = req;
        ptr_wide                      = '0;
        ptr_wide[$clog2(NREQ)-1:0]    = pointer;
        pick                          = rr_pick(req_wide, ptr_wide, NREQ);
        valid                         = pick.valid;
        sel                           = pick.idx[$clog2(NREQ)-1:0];
        onehot                        = '0;
        for (int i = 0; i < NREQ; i++) begin
            onehot[i] = pick.valid && (pick.idx == 4'(i));
        end
    end

endmodule

// File: rtl/counter_share_scheduler.sv
// Time-shares one up-counter between NREQ requesters, round-robin, one interval per grant.
// Define COUNTER_PRESCALE_EN to advance the counter only every PRESCALE cycles.
module counter_share_scheduler
    import counter_share_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_len,
    input  logic                     abort,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic [WIDTH-1:0]         count
);

    localparam int PW = $clog2(NREQ);

    state_t            state;
    logic [PW-1:0]     pointer;
    logic [WIDTH-1:0]  target;
    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     sel;
    logic              pick_valid;
    logic [WIDTH-1:0]  sel_len;
    logic              cancel;
    logic              step;

    rr_arbiter_onehot #(.NREQ(NREQ)) u_arbiter (
        .req     (req),
        .pointer (pointer),
        .onehot  (pick_onehot),
        .sel     (sel),
        .valid   (pick_valid)
    );

    assign sel_len = req_len[sel*WIDTH +: WIDTH];
    assign cancel  = abort || !req[owner];

`ifdef COUNTER_PRESCALE_EN
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PSW-1:0] presc;

    assign step = (presc == PSW'(PRESCALE - 1));

    // Free-runs only inside an uncancelled interval, so every grant starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (state == RUN && !cancel) begin
            presc <= step ? '0 : presc + PSW'(1);
        end else begin
            presc <= '0;
        end
    end
`else
    // Every cycle is a step; PRESCALE only matters for legal configurations (>= 1).
    assign step = (PRESCALE >= 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            owner   <= '0;
            count   <= '0;
            target  <= '0;
            pointer <= PW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (pick_valid) begin
                        target <= (sel_len == '0) ? WIDTH'(1) : sel_len;
                        owner  <= sel;
                        gnt    <= pick_onehot;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Cancellation wins over a same-cycle terminal match: no done pulse.
                    if (cancel) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        count   <= '0;
                        pointer <= owner;
                    end else if (step) begin
                        if (count == target - WIDTH'(1)) begin
                            state <= DONE;
                            gnt   <= '0;
                        end else begin
                            count <= count + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    count   <= '0;
                    pointer <= owner;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        done = '0;
        if (state == DONE) begin
            done[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_share_scheduler.sv
// Scoreboard bench for counter_share_scheduler: stimulus queues expected intervals, a monitor checks them.
// Works in both builds; with COUNTER_PRESCALE_EN every interval stretches by PRESCALE.
module tb_counter_share_scheduler;

    localparam int N = 4;
    localparam int W = 8;
`ifdef COUNTER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           abort;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [1:0]     owner;
    logic [W-1:0]   count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int len;
        bit has_done;
        int gap;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    counter_share_scheduler #(.NREQ(N), .WIDTH(W), .PRESCALE(P)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .abort   (abort),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .owner   (owner),
        .count   (count)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req_val);
        req = req_val;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*W +: W] = W'(v);
    endtask

    task automatic push_exp(input int idx, input int len, input bit has_done, input int gap);
        exp_t e;
        e.idx = idx; e.len = len; e.has_done = has_done; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; checks the asynchronous clear before the next clock edge.
    task automatic applyReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_gnt",   int'(gnt),   0);
        checkOutput("rst_done",  int'(done),  0);
        checkOutput("rst_busy",  int'(busy),  0);
        checkOutput("rst_owner", int'(owner), 0);
        checkOutput("rst_count", int'(count), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt == '0 && cyc < budget);
        if (gnt == '0) checkOutput("timeout_gnt", 1, 0);
    endtask

    task automatic wait_count(input int value, input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(gnt != '0 && int'(count) == value) && cyc < budget);
        if (!(gnt != '0 && int'(count) == value)) checkOutput("timeout_count", 1, 0);
    endtask

    task automatic wait_dones(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done != '0) seen++;
        end
        if (seen < n) checkOutput("timeout_done", seen, n);
    endtask

    // Monitor: compares every interval the DUT presents against the queued expectation.
    initial begin : monitor
        logic [N-1:0] prev_gnt;
        int   hi;
        int   lo;
        exp_t cur;
        exp_t fin;
        prev_gnt = '0;
        hi = 0;
        lo = 0;
        forever begin
            @(negedge clk);
            if (gnt == '0 && prev_gnt != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_interval", 1, 0);
                end else begin
                    fin = exp_q.pop_front();
                    checkOutput("gnt_length", hi, fin.len);
                    checkOutput("done_at_end", int'(done), fin.has_done ? (1 << fin.idx) : 0);
                    checkOutput("busy_at_end", int'(busy), fin.has_done ? 1 : 0);
                end
            end else if (done != '0) begin
                checkOutput("stray_done", int'(done), 0);
            end
            if (gnt != '0 && prev_gnt == '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_grant", int'(gnt), 0);
                end else begin
                    cur = exp_q[0];
                    checkOutput("gnt_onehot", int'(gnt), 1 << cur.idx);
                    checkOutput("owner", int'(owner), cur.idx);
                    checkOutput("busy_at_grant", int'(busy), 1);
                    if (cur.gap >= 0) checkOutput("grant_gap", lo, cur.gap);
                end
                hi = 0;
                lo = 0;
            end
            if (gnt != '0) begin
                hi++;
                checkOutput("count_value", int'(count), (hi - 1) / P);
            end else begin
                lo++;
            end
            prev_gnt = gnt;
        end
    end

    initial begin : stimulus
        rst     = 1'b1;
        abort   = 1'b0;
        req     = '0;
        req_len = '0;
        repeat (3) @(negedge clk);
        checkOutput("init_gnt",   int'(gnt),   0);
        checkOutput("init_busy",  int'(busy),  0);
        checkOutput("init_owner", int'(owner), 0);
        checkOutput("init_count", int'(count), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single request, length 5, length change after grant ignored");
        set_len(0, 5);
        push_exp(0, 5 * P, 1'b1, -1);
        applyStimulus(4'b0001);
        wait_gnt(20);
        set_len(0, 2);
        wait_dones(1, 40 * P);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        $display("[TB] round robin over all four requesters");
        applyReset();
        for (int i = 0; i < N; i++) set_len(i, 3);
        push_exp(0, 3 * P, 1'b1, -1);
        push_exp(1, 3 * P, 1'b1, 2);
        push_exp(2, 3 * P, 1'b1, 2);
        push_exp(3, 3 * P, 1'b1, 2);
        push_exp(0, 3 * P, 1'b1, 2);
        applyStimulus(4'b1111);
        wait_dones(5, 100 * P);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        $display("[TB] zero length treated as one");
        set_len(1, 0);
        push_exp(1, 1 * P, 1'b1, -1);
        applyStimulus(4'b0010);
        wait_dones(1, 20 * P);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        $display("[TB] withdraw of requester 2, then requester 3 served");
        set_len(2, 10);
        set_len(3, 3);
        push_exp(2, 4 * P + 1, 1'b0, -1);
        push_exp(3, 3 * P, 1'b1, 1);
        applyStimulus(4'b1100);
        wait_count(4, 40 * P);
        applyStimulus(4'b1000);
        wait_dones(1, 40 * P);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        $display("[TB] abort on the terminal cycle");
        set_len(0, 4);
        push_exp(0, 4 * P, 1'b0, -1);
        applyStimulus(4'b0001);
        wait_gnt(20);
        repeat (4 * P - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-run, pointer restarts");
        set_len(2, 20);
        push_exp(2, 7 * P + 1, 1'b0, -1);
        applyStimulus(4'b0100);
        wait_count(7, 40 * P);
        applyReset();
        set_len(0, 2);
        set_len(3, 2);
        push_exp(0, 2 * P, 1'b1, -1);
        applyStimulus(4'b1001);
        wait_dones(1, 40 * P);
        applyStimulus(4'b0000);
        repeat (4) @(negedge clk);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
